// File: rtl/instruction_encoder.sv
// Packs symbolic instruction requests into 16-bit ISA words and writes them to consecutive imem addresses.
// One request per cycle; each word is written one cycle after its request is accepted; in_ready is high only in LOAD.
module instruction_encoder #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_mnem,
    input  logic [3:0]    in_ra,
    input  logic [3:0]    in_rb,
    input  logic [7:0]    in_imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [15:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic          err,
    output logic [AW:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_FULL = 2'd3
    } state_e;

    localparam logic [4:0] M_ADD   = 5'd0;
    localparam logic [4:0] M_SUB   = 5'd1;
    localparam logic [4:0] M_CMP   = 5'd2;
    localparam logic [4:0] M_AND   = 5'd3;
    localparam logic [4:0] M_OR    = 5'd4;
    localparam logic [4:0] M_XOR   = 5'd5;
    localparam logic [4:0] M_MOV   = 5'd6;
    localparam logic [4:0] M_ADDI  = 5'd7;
    localparam logic [4:0] M_SUBI  = 5'd8;
    localparam logic [4:0] M_CMPI  = 5'd9;
    localparam logic [4:0] M_ANDI  = 5'd10;
    localparam logic [4:0] M_ORI   = 5'd11;
    localparam logic [4:0] M_XORI  = 5'd12;
    localparam logic [4:0] M_MOVI  = 5'd13;
    localparam logic [4:0] M_LUI   = 5'd14;
    localparam logic [4:0] M_LSH   = 5'd15;
    localparam logic [4:0] M_LSHI  = 5'd16;
    localparam logic [4:0] M_LOAD  = 5'd17;
    localparam logic [4:0] M_STOR  = 5'd18;
    localparam logic [4:0] M_JAL   = 5'd19;
    localparam logic [4:0] M_JCOND = 5'd20;
    localparam logic [4:0] M_BCOND = 5'd21;

    localparam logic [AW-1:0] PTR_MAX = '1;

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic          err_q;
    logic [AW:0]   cnt_q;

    logic [15:0]   word_d;
    logic          legal_d;
    logic          accept;
    logic          last_slot;

    always_comb begin
        word_d  = 16'h0000;
        legal_d = 1'b1;
        case (in_mnem)
            M_ADD:   word_d = {4'b0000, in_ra, 4'b0101, in_rb};
            M_SUB:   word_d = {4'b0000, in_ra, 4'b1001, in_rb};
            M_CMP:   word_d = {4'b0000, in_ra, 4'b1011, in_rb};
            M_AND:   word_d = {4'b0000, in_ra, 4'b0001, in_rb};
            M_OR:    word_d = {4'b0000, in_ra, 4'b0010, in_rb};
            M_XOR:   word_d = {4'b0000, in_ra, 4'b0011, in_rb};
            M_MOV:   word_d = {4'b0000, in_ra, 4'b1101, in_rb};
            M_ADDI:  word_d = {4'b0101, in_ra, in_imm};
            M_SUBI:  word_d = {4'b1001, in_ra, in_imm};
            M_CMPI:  word_d = {4'b1011, in_ra, in_imm};
            M_ANDI:  word_d = {4'b0001, in_ra, in_imm};
            M_ORI:   word_d = {4'b0010, in_ra, in_imm};
            M_XORI:  word_d = {4'b0011, in_ra, in_imm};
            M_MOVI:  word_d = {4'b1101, in_ra, in_imm};
            M_LUI:   word_d = {4'b1111, in_ra, in_imm};
            M_LSH:   word_d = {4'b1000, in_ra, 4'b0100, in_rb};
            M_LSHI: begin
                // Shift amount must fit a 5-bit signed field: upper nibble is pure sign extension.
                word_d  = {4'b1000, in_ra, 3'b000, in_imm[4], in_imm[3:0]};
                legal_d = (in_imm[7:4] == 4'b0000) || (in_imm[7:4] == 4'b1111);
            end
            M_LOAD:  word_d = {4'b0100, in_ra, 4'b0000, in_rb};
            M_STOR:  word_d = {4'b0100, in_ra, 4'b0100, in_rb};
            M_JAL:   word_d = {4'b0100, in_ra, 4'b1000, in_rb};
            M_JCOND: word_d = {4'b0100, in_ra, 4'b1100, in_rb};
            M_BCOND: word_d = {4'b1100, in_ra, in_imm};
            default: legal_d = 1'b0;
        endcase
    end

    assign accept    = in_valid && (state_q == S_LOAD);
    assign last_slot = (ptr_q == PTR_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            we_q <= 1'b0;
            if (accept && legal_d) begin
                we_q    <= 1'b1;
                addr_q  <= ptr_q;
                wdata_q <= word_d;
                cnt_q   <= cnt_q + (AW+1)'(1);
                // Pointer parks on the top address; FULL stops further acceptance.
                if (!last_slot) begin
                    ptr_q <= ptr_q + AW'(1);
                end
            end
            if (accept && !legal_d) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE, S_FULL: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        ptr_q   <= start_addr;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept && legal_d && last_slot) begin
                        state_q <= S_FULL;
                    end else if (finish) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == S_LOAD) || we_q;
    assign done       = (state_q == S_DONE);
    assign full       = (state_q == S_FULL);
    assign err        = err_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encoding table plus handshake, full, illegal, finish and reset sequences.
module tb_instruction_encoder;

    logic        clk;
    logic        rst;

    logic        start, finish, in_valid;
    logic [7:0]  start_addr;
    logic [4:0]  in_mnem;
    logic [3:0]  in_ra, in_rb;
    logic [7:0]  in_imm;
    logic        in_ready, imem_we, busy, done, full, err;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [8:0]  word_count;

    logic        s_start, s_finish, s_in_valid;
    logic [1:0]  s_start_addr;
    logic [4:0]  s_in_mnem;
    logic [3:0]  s_in_ra, s_in_rb;
    logic [7:0]  s_in_imm;
    logic        s_in_ready, s_imem_we, s_busy, s_done, s_full, s_err;
    logic [1:0]  s_imem_addr;
    logic [15:0] s_imem_wdata;
    logic [2:0]  s_word_count;

    int passed = 0;
    int total  = 0;

    instruction_encoder #(.AW(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_ra(in_ra),
        .in_rb(in_rb), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .full(full), .err(err),
        .word_count(word_count)
    );

    instruction_encoder #(.AW(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .start_addr(s_start_addr), .finish(s_finish),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mnem(s_in_mnem), .in_ra(s_in_ra),
        .in_rb(s_in_rb), .in_imm(s_in_imm), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .busy(s_busy), .done(s_done), .full(s_full), .err(s_err),
        .word_count(s_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  mnem;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [7:0]  imm;
        logic [15:0] word;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] m, input logic [3:0] a, input logic [3:0] b, input logic [7:0] i);
        in_mnem = m;
        in_ra   = a;
        in_rb   = b;
        in_imm  = i;
    endtask

    initial begin
        // Non-imm fields are deliberately nonzero so field leakage shows up in the word.
        vecs[0]  = '{5'd0,  4'h3, 4'h5, 8'hAA, 16'h0355};
        vecs[1]  = '{5'd7,  4'h2, 4'hF, 8'hFF, 16'h52FF};
        vecs[2]  = '{5'd16, 4'h1, 4'hF, 8'hFD, 16'h811D};
        vecs[3]  = '{5'd21, 4'h0, 4'hF, 8'hF0, 16'hC0F0};
        vecs[4]  = '{5'd19, 4'hE, 4'h7, 8'hAA, 16'h4E87};
        vecs[5]  = '{5'd1,  4'h1, 4'h2, 8'hAA, 16'h0192};
        vecs[6]  = '{5'd2,  4'hA, 4'hB, 8'hAA, 16'h0ABB};
        vecs[7]  = '{5'd3,  4'h4, 4'h6, 8'hAA, 16'h0416};
        vecs[8]  = '{5'd4,  4'h7, 4'h8, 8'hAA, 16'h0728};
        vecs[9]  = '{5'd5,  4'h9, 4'h1, 8'hAA, 16'h0931};
        vecs[10] = '{5'd6,  4'hF, 4'h0, 8'hAA, 16'h0FD0};
        vecs[11] = '{5'd8,  4'h3, 4'hF, 8'h12, 16'h9312};
        vecs[12] = '{5'd9,  4'h5, 4'hF, 8'h80, 16'hB580};
        vecs[13] = '{5'd10, 4'h6, 4'hF, 8'h0F, 16'h160F};
        vecs[14] = '{5'd11, 4'h7, 4'hF, 8'hA5, 16'h27A5};
        vecs[15] = '{5'd12, 4'h8, 4'hF, 8'h3C, 16'h383C};
        vecs[16] = '{5'd13, 4'h9, 4'hF, 8'h01, 16'hD901};
        vecs[17] = '{5'd14, 4'hA, 4'hF, 8'hBE, 16'hFABE};
        vecs[18] = '{5'd15, 4'h2, 4'h3, 8'hAA, 16'h8243};
        vecs[19] = '{5'd16, 4'h3, 4'hF, 8'h05, 16'h8305};
        vecs[20] = '{5'd17, 4'h4, 4'h5, 8'hAA, 16'h4405};
        vecs[21] = '{5'd18, 4'h6, 4'h7, 8'hAA, 16'h4647};
        vecs[22] = '{5'd20, 4'h1, 4'hC, 8'hAA, 16'h41CC};

        rst = 1'b1;
        start = 1'b0; finish = 1'b0; in_valid = 1'b0; start_addr = 8'h00;
        drive(5'd0, 4'h0, 4'h0, 8'h00);
        s_start = 1'b0; s_finish = 1'b0; s_in_valid = 1'b0; s_start_addr = 2'd0;
        s_in_mnem = 5'd0; s_in_ra = 4'h0; s_in_rb = 4'h0; s_in_imm = 8'h00;

        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", word_count, 0);

        tick();
        rst = 1'b0;
        tick();
        chk("idle_ready", in_ready, 0);

        start = 1'b1; start_addr = 8'h10;
        tick();
        start = 1'b0;
        chk("load_ready", in_ready, 1);
        chk("load_busy", busy, 1);

        in_valid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].mnem, vecs[i].ra, vecs[i].rb, vecs[i].imm);
            tick();
            chk($sformatf("vec%0d_we", i), imem_we, 1);
            chk($sformatf("vec%0d_addr", i), imem_addr, 32'h10 + i);
            chk($sformatf("vec%0d_word", i), imem_wdata, vecs[i].word);
            chk($sformatf("vec%0d_count", i), word_count, i + 1);
        end
        in_valid = 1'b0;
        tick();
        chk("idle_gap_we", imem_we, 0);

        // Illegal mnemonic, then out-of-range LSHI, then a legal ADD at the unchanged pointer.
        in_valid = 1'b1;
        drive(5'd25, 4'h1, 4'h2, 8'h00);
        tick();
        chk("ill_mnem_we", imem_we, 0);
        chk("ill_mnem_err", err, 1);
        chk("ill_mnem_ready", in_ready, 1);
        drive(5'd16, 4'h1, 4'h0, 8'h40);
        tick();
        chk("ill_lshi_we", imem_we, 0);
        chk("ill_lshi_count", word_count, NV);
        drive(5'd0, 4'h1, 4'h2, 8'h00);
        tick();
        chk("post_ill_we", imem_we, 1);
        chk("post_ill_addr", imem_addr, 32'h10 + NV);
        chk("post_ill_word", imem_wdata, 16'h0152);
        chk("post_ill_err", err, 1);

        // finish together with a valid request: written, then DONE.
        drive(5'd13, 4'h4, 4'h0, 8'h7A);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        in_valid = 1'b0;
        chk("fin_we", imem_we, 1);
        chk("fin_addr", imem_addr, 32'h11 + NV);
        chk("fin_word", imem_wdata, 16'hD47A);
        chk("fin_done", done, 1);
        chk("fin_ready", in_ready, 0);
        chk("fin_busy", busy, 1);
        tick();
        chk("done_we", imem_we, 0);
        chk("done_busy", busy, 0);
        chk("done_count", word_count, NV + 2);

        start = 1'b1; start_addr = 8'h40;
        tick();
        start = 1'b0;
        chk("restart_err", err, 0);
        chk("restart_count", word_count, 0);
        chk("restart_done", done, 0);
        chk("restart_ready", in_ready, 1);

        // start while loading must not move the pointer.
        start = 1'b1; start_addr = 8'h80;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        drive(5'd6, 4'h2, 4'h3, 8'h00);
        tick();
        in_valid = 1'b0;
        chk("ign_start_addr", imem_addr, 32'h40);
        chk("ign_start_word", imem_wdata, 16'h02D3);

        // Reset in the cycle after an acceptance.
        in_valid = 1'b1;
        drive(5'd0, 4'h5, 4'h6, 8'h00);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_we", imem_we, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_wdata", imem_wdata, 0);
        chk("mid_rst_count", word_count, 0);
        #2;
        rst = 1'b0;
        tick();
        chk("post_rst_we", imem_we, 0);
        chk("post_rst_ready", in_ready, 0);

        // AW=2: only addresses 2 and 3 are writable.
        s_start = 1'b1; s_start_addr = 2'd2;
        tick();
        s_start = 1'b0;
        s_in_valid = 1'b1;
        s_in_mnem = 5'd0; s_in_ra = 4'h1; s_in_rb = 4'h1;
        tick();
        chk("small_w0_we", s_imem_we, 1);
        chk("small_w0_addr", s_imem_addr, 2);
        chk("small_w0_word", s_imem_wdata, 16'h0151);
        chk("small_w0_full", s_full, 0);
        s_in_ra = 4'h2; s_in_rb = 4'h2;
        tick();
        chk("small_w1_we", s_imem_we, 1);
        chk("small_w1_addr", s_imem_addr, 3);
        chk("small_w1_word", s_imem_wdata, 16'h0252);
        chk("small_w1_full", s_full, 1);
        chk("small_w1_ready", s_in_ready, 0);
        s_in_ra = 4'h3; s_in_rb = 4'h3;
        tick();
        chk("small_w2_we", s_imem_we, 0);
        chk("small_w2_count", s_word_count, 2);
        tick();
        chk("small_hold_we", s_imem_we, 0);
        chk("small_hold_full", s_full, 1);
        s_in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
